// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle control unit: state encoding,
// opcode constants and halt cause codes.
// Optional feature macro: MC_CTRL_MULDIV_EN adds the MULDIV state.
package mc_ctrl_pkg;

  typedef enum logic [4:0] {
    ST_FETCH   = 5'd0,
    ST_DECODE  = 5'd1,
    ST_MEMADR  = 5'd2,
    ST_MEMREAD = 5'd3,
    ST_MEMWB   = 5'd4,
    ST_MEMWR   = 5'd5,
    ST_EXECR   = 5'd6,
    ST_EXECI   = 5'd7,
    ST_ALUWB   = 5'd8,
    ST_JAL     = 5'd9,
    ST_JALR    = 5'd10,
    ST_BRANCH  = 5'd11,
    ST_AUIPC   = 5'd12,
    ST_LUI     = 5'd13,
`ifdef MC_CTRL_MULDIV_EN
    ST_MULDIV  = 5'd14,
`endif
    ST_HALT    = 5'd15
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_ILLEGAL = 2'd1,
    CAUSE_TIMEOUT = 2'd2,
    CAUSE_EBREAK  = 2'd3
  } cause_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // States that wait on the memory handshake and are guarded by the timer.
  function automatic logic is_wait_state(input state_t s);
    return (s == ST_FETCH) || (s == ST_MEMREAD) || (s == ST_MEMWR);
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Memory wait counter. Cleared on entry to a waiting state, counts cycles
// without mem_ready; at_max flags the last allowed wait cycle.
module mc_wait_timer #(
  parameter int TIMEOUT_W = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  input  logic inc,
  output logic at_max
);

  logic [TIMEOUT_W-1:0] count;

  // Wait counter; clear has priority so a state change always restarts it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (clear) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of block ordering.
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

  assign at_max = &count;

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle RISC-V style control unit: two-process FSM driving datapath
// selects and strobes, with memory bus timeout and sticky halt.
// Optional feature macro: MC_CTRL_MULDIV_EN enables the MULDIV state for
// R-type instructions with funct7[0]=1; otherwise they halt as illegal.
module mc_control_unit
  import mc_ctrl_pkg::*;
#(
  parameter int TIMEOUT_W = 4,
  parameter int SEL_W     = 3
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             funct7_5,
  input  logic             funct7_0,
  input  logic             mem_ready,
  input  logic             md_done,
  output logic             pc_write,
  output logic             ir_write,
  output logic             pc_src,
  output logic             reg_write,
  output logic             imm,
  output logic             mem_write,
  output logic             mem_req,
  output logic             branch,
  output logic             md_start,
  output logic             ebreak,
  output logic             halted,
  output logic [1:0]       adr_src,
  output logic [1:0]       alu_op,
  output logic [SEL_W-1:0] alu_src_a,
  output logic [SEL_W-1:0] alu_src_b,
  output logic [SEL_W-1:0] result_src,
  output logic [1:0]       cause,
  output logic [4:0]       state_o
);

  state_t state, state_next;
  cause_t cause_q, cause_next;
  logic   timer_at_max;
  logic   timeout;
  logic   md_prev;

  mc_wait_timer #(.TIMEOUT_W(TIMEOUT_W)) u_wait_timer (
    .clk    (clk),
    .resetn (resetn),
    .clear  (state_next != state),
    .inc    (is_wait_state(state) && !mem_ready),
    .at_max (timer_at_max)
  );

  // Ready wins over timeout: only a not-ready cycle at the limit expires.
  assign timeout = is_wait_state(state) && timer_at_max && !mem_ready;

  // State and cause registers; cause is captured only on entry to HALT.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= ST_FETCH;
      cause_q <= CAUSE_NONE;
    end else begin
      state <= state_next;
      if (state != ST_HALT && state_next == ST_HALT) cause_q <= cause_next;
    end
  end

`ifdef MC_CTRL_MULDIV_EN
  // Remembers the previous cycle was MULDIV: gives the one-cycle md_start
  // and selects the mul/div result in the following ALUWB.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) md_prev <= 1'b0;
    else         md_prev <= (state == ST_MULDIV);
  end
`else
  logic unused_md_done;
  assign unused_md_done = md_done;
  assign md_prev        = 1'b0;
`endif

  // Next-state and halt-cause selection.
  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    state_next = state;
    cause_next = CAUSE_NONE;
    case (state)
      ST_FETCH: begin
        if (mem_ready) state_next = ST_DECODE;
        else if (timeout) begin
          state_next = ST_HALT;
          cause_next = CAUSE_TIMEOUT;
        end
      end
      ST_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_next = ST_MEMADR;
          OP_R: begin
            if (!funct7_0) state_next = ST_EXECR;
            else begin
`ifdef MC_CTRL_MULDIV_EN
              state_next = ST_MULDIV;
`else
              state_next = ST_HALT;
              cause_next = CAUSE_ILLEGAL;
`endif
            end
          end
          OP_IMM:    state_next = ST_EXECI;
          OP_JAL:    state_next = ST_JAL;
          OP_JALR:   state_next = ST_JALR;
          OP_BRANCH: state_next = ST_BRANCH;
          OP_AUIPC:  state_next = ST_AUIPC;
          OP_LUI:    state_next = ST_LUI;
          OP_FENCE:  state_next = ST_FETCH;
          OP_SYSTEM: begin
            state_next = ST_HALT;
            cause_next = (funct3 == 3'd0 && !funct7_0 && !funct7_5)
                         ? CAUSE_EBREAK : CAUSE_ILLEGAL;
          end
          default: begin
            state_next = ST_HALT;
            cause_next = CAUSE_ILLEGAL;
          end
        endcase
      end
      ST_MEMADR: state_next = (op == OP_LOAD) ? ST_MEMREAD : ST_MEMWR;
      ST_MEMREAD, ST_MEMWR: begin
        if (mem_ready) state_next = (state == ST_MEMREAD) ? ST_MEMWB : ST_FETCH;
        else if (timeout) begin
          state_next = ST_HALT;
          cause_next = CAUSE_TIMEOUT;
        end
      end
      ST_MEMWB, ST_ALUWB, ST_BRANCH: state_next = ST_FETCH;
      ST_EXECR, ST_EXECI, ST_JAL, ST_JALR, ST_AUIPC, ST_LUI:
        state_next = ST_ALUWB;
`ifdef MC_CTRL_MULDIV_EN
      ST_MULDIV: if (md_done) state_next = ST_ALUWB;
`endif
      ST_HALT: state_next = ST_HALT;
      default: state_next = ST_FETCH;
    endcase
  end

  // Per-state outputs; all forced low while reset is asserted so an
  // interrupted bus access is dropped immediately.
  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    pc_src     = 1'b0;
    reg_write  = 1'b0;
    imm        = 1'b0;
    mem_write  = 1'b0;
    mem_req    = 1'b0;
    branch     = 1'b0;
    md_start   = 1'b0;
    ebreak     = 1'b0;
    halted     = 1'b0;
    adr_src    = 2'd0;
    alu_op     = 2'd0;
    alu_src_a  = '0;
    alu_src_b  = '0;
    result_src = '0;
    if (resetn) begin
      case (state)
        ST_FETCH: begin
          mem_req   = 1'b1;
          alu_src_b = SEL_W'(1);
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        ST_DECODE: begin
          alu_src_a = SEL_W'(2);
          alu_src_b = SEL_W'(2);
        end
        ST_MEMADR: begin
          alu_src_a = SEL_W'(1);
          alu_src_b = SEL_W'(2);
        end
        ST_MEMREAD: begin
          mem_req = 1'b1;
          adr_src = 2'd1;
        end
        ST_MEMWR: begin
          mem_req   = 1'b1;
          mem_write = 1'b1;
          adr_src   = 2'd1;
        end
        ST_MEMWB: begin
          reg_write  = 1'b1;
          result_src = SEL_W'(1);
        end
        ST_ALUWB: begin
          reg_write  = 1'b1;
          result_src = md_prev ? SEL_W'(2) : SEL_W'(0);
        end
        ST_EXECR: begin
          alu_src_a = SEL_W'(1);
          alu_op    = 2'd2;
        end
        ST_EXECI: begin
          alu_src_a = SEL_W'(1);
          alu_src_b = SEL_W'(2);
          alu_op    = 2'd2;
          imm       = 1'b1;
        end
        ST_JAL, ST_JALR: begin
          alu_src_a = SEL_W'(2);
          alu_src_b = SEL_W'(1);
          pc_write  = 1'b1;
          pc_src    = 1'b1;
          imm       = (state == ST_JALR);
        end
        ST_BRANCH: begin
          alu_src_a = SEL_W'(1);
          alu_op    = 2'd1;
          branch    = 1'b1;
          pc_src    = 1'b1;
        end
        ST_AUIPC: begin
          alu_src_a = SEL_W'(2);
          alu_src_b = SEL_W'(2);
        end
        ST_LUI: begin
          alu_src_a = SEL_W'(3);
          alu_src_b = SEL_W'(2);
        end
`ifdef MC_CTRL_MULDIV_EN
        ST_MULDIV: begin
          alu_src_a  = SEL_W'(1);
          result_src = SEL_W'(2);
          md_start   = !md_prev;
        end
`endif
        ST_HALT: begin
          halted = 1'b1;
          ebreak = (cause_q == CAUSE_EBREAK);
        end
        default: ;
      endcase
    end
  end

  assign cause   = cause_q;
  assign state_o = state;

endmodule

// File: tb/tb_mc_control_unit.sv
// Self-checking bench for mc_control_unit: directed and randomized
// instruction streams checked cycle by cycle against a reference model that
// derives the expected state path from each instruction's class.
module tb_mc_control_unit;
  import mc_ctrl_pkg::*;

  logic       clk;
  logic       resetn;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7_5, funct7_0, mem_ready, md_done;
  logic       pc_write, ir_write, pc_src, reg_write, imm, mem_write, mem_req;
  logic       branch, md_start, ebreak, halted;
  logic [1:0] adr_src, alu_op, cause;
  logic [2:0] alu_src_a, alu_src_b, result_src;
  logic [4:0] state_o;

  mc_control_unit dut (
    .clk(clk), .resetn(resetn), .op(op), .funct3(funct3),
    .funct7_5(funct7_5), .funct7_0(funct7_0), .mem_ready(mem_ready),
    .md_done(md_done), .pc_write(pc_write), .ir_write(ir_write),
    .pc_src(pc_src), .reg_write(reg_write), .imm(imm),
    .mem_write(mem_write), .mem_req(mem_req), .branch(branch),
    .md_start(md_start), .ebreak(ebreak), .halted(halted),
    .adr_src(adr_src), .alu_op(alu_op), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .result_src(result_src), .cause(cause),
    .state_o(state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic pc_write, ir_write, pc_src, reg_write, imm, mem_write, mem_req;
    logic branch, md_start, ebreak, halted;
    logic [1:0] adr_src, alu_op;
    logic [2:0] a, b, r;
    logic [1:0] cause;
  } outs_t;

  typedef struct {
    state_t     st;
    logic       ready;
    logic       done;
    logic       md_first;
    logic       from_md;
    logic [1:0] cause;
  } step_t;

  step_t path[$];
  int    total  = 0;
  int    passed = 0;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Expected outputs of one cycle, straight from the per-state output table.
  function automatic outs_t exp_outs(input step_t s);
    outs_t o = '0;
    o.cause = s.cause;
    case (s.st)
      ST_FETCH:   begin o.mem_req = 1; o.b = 1; o.ir_write = s.ready; o.pc_write = s.ready; end
      ST_DECODE:  begin o.a = 2; o.b = 2; end
      ST_MEMADR:  begin o.a = 1; o.b = 2; end
      ST_MEMREAD: begin o.mem_req = 1; o.adr_src = 1; end
      ST_MEMWR:   begin o.mem_req = 1; o.mem_write = 1; o.adr_src = 1; end
      ST_MEMWB:   begin o.reg_write = 1; o.r = 1; end
      ST_ALUWB:   begin o.reg_write = 1; o.r = s.from_md ? 3'd2 : 3'd0; end
      ST_EXECR:   begin o.a = 1; o.alu_op = 2; end
      ST_EXECI:   begin o.a = 1; o.b = 2; o.alu_op = 2; o.imm = 1; end
      ST_JAL:     begin o.a = 2; o.b = 1; o.pc_write = 1; o.pc_src = 1; end
      ST_JALR:    begin o.a = 2; o.b = 1; o.pc_write = 1; o.pc_src = 1; o.imm = 1; end
      ST_BRANCH:  begin o.a = 1; o.alu_op = 1; o.branch = 1; o.pc_src = 1; end
      ST_AUIPC:   begin o.a = 2; o.b = 2; end
      ST_LUI:     begin o.a = 3; o.b = 2; end
`ifdef MC_CTRL_MULDIV_EN
      ST_MULDIV:  begin o.a = 1; o.r = 2; o.md_start = s.md_first; end
`endif
      ST_HALT:    begin o.halted = 1; o.ebreak = (s.cause == 2'd3); end
      default: ;
    endcase
    return o;
  endfunction

  task automatic push(input state_t st, input logic rdy, input logic dn,
                      input logic first = 1'b0, input logic from_md = 1'b0,
                      input logic [1:0] c = 2'd0);
    step_t s;
    s.st = st; s.ready = rdy; s.done = dn;
    s.md_first = first; s.from_md = from_md; s.cause = c;
    path.push_back(s);
  endtask

  task automatic push_dc(input state_t st, input logic from_md = 1'b0);
    push(st, 1'($urandom), 1'($urandom), 1'b0, from_md);
  endtask

  // Memory wait: 'waits' not-ready cycles then ready; 2^4-1 counted waits
  // allowed, so the 16th not-ready cycle expires. Returns 1 on timeout.
  task automatic push_wait(input state_t st, input int waits, output bit to);
    to = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i == waits) begin
        push(st, 1'b1, 1'($urandom));
        to = 1'b0;
        break;
      end
      push(st, 1'b0, 1'($urandom));
    end
  endtask

  // Reference model: expected cycle sequence of one instruction.
  task automatic build(input logic [6:0] o, input logic [2:0] f3,
                       input logic f75, input logic f70, input int wf,
                       input int wm, input int md_d, output bit hlt);
    bit to;
    logic [1:0] hc;
    path.delete();
    hlt = 1'b0;
    hc  = 2'd0;
    push_wait(ST_FETCH, wf, to);
    if (to) begin hlt = 1; hc = 2; end
    else begin
      push_dc(ST_DECODE);
      case (o)
        OP_LOAD: begin
          push_dc(ST_MEMADR);
          push_wait(ST_MEMREAD, wm, to);
          if (to) begin hlt = 1; hc = 2; end else push_dc(ST_MEMWB);
        end
        OP_STORE: begin
          push_dc(ST_MEMADR);
          push_wait(ST_MEMWR, wm, to);
          if (to) begin hlt = 1; hc = 2; end
        end
        OP_R: begin
          if (f70) begin
`ifdef MC_CTRL_MULDIV_EN
            for (int i = 0; i <= md_d; i++)
              push(ST_MULDIV, 1'($urandom), (i == md_d), (i == 0));
            push_dc(ST_ALUWB, 1'b1);
`else
            hlt = 1; hc = 1;
`endif
          end else begin
            push_dc(ST_EXECR); push_dc(ST_ALUWB);
          end
        end
        OP_IMM:    begin push_dc(ST_EXECI); push_dc(ST_ALUWB); end
        OP_JAL:    begin push_dc(ST_JAL);   push_dc(ST_ALUWB); end
        OP_JALR:   begin push_dc(ST_JALR);  push_dc(ST_ALUWB); end
        OP_BRANCH: push_dc(ST_BRANCH);
        OP_AUIPC:  begin push_dc(ST_AUIPC); push_dc(ST_ALUWB); end
        OP_LUI:    begin push_dc(ST_LUI);   push_dc(ST_ALUWB); end
        OP_FENCE:  ;
        OP_SYSTEM: begin
          hlt = 1;
          hc  = (f3 == 0 && !f70 && !f75) ? 2'd3 : 2'd1;
        end
        default: begin hlt = 1; hc = 1; end
      endcase
    end
    if (hlt)
      for (int i = 0; i < 3; i++) push(ST_HALT, 1'($urandom), 1'($urandom), 0, 0, hc);
  endtask

  // Called at a falling edge: reset across one rising edge, release at the
  // next falling edge so the first fetch happens on the edge after that.
  task automatic pulse_reset();
    #1 resetn = 1'b0;
    #2;
    check("rst_state", state_o, ST_FETCH);
    check("rst_cause", cause, 0);
    check("rst_mem_req", mem_req, 0);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic instr(input logic [6:0] o, input logic [2:0] f3,
                       input logic f75, input logic f70, input int wf,
                       input int wm, input int md_d,
                       input bit reset_in_memwr = 1'b0);
    bit hlt;
    outs_t obs;
    op = o; funct3 = f3; funct7_5 = f75; funct7_0 = f70;
    build(o, f3, f75, f70, wf, wm, md_d, hlt);
    foreach (path[i]) begin
      mem_ready = path[i].ready;
      md_done   = path[i].done;
      #1;
      obs = {pc_write, ir_write, pc_src, reg_write, imm, mem_write, mem_req,
             branch, md_start, ebreak, halted, adr_src, alu_op, alu_src_a,
             alu_src_b, result_src, cause};
      check($sformatf("state op=%b step %0d", o, i), state_o, path[i].st);
      check($sformatf("outs %s op=%b step %0d", path[i].st.name(), o, i),
            obs, exp_outs(path[i]));
      if (reset_in_memwr && path[i].st == ST_MEMWR) begin
        #1 resetn = 1'b0;
        #1;
        check("memwr_rst mem_write", mem_write, 0);
        check("memwr_rst mem_req", mem_req, 0);
        check("memwr_rst state", state_o, ST_FETCH);
        check("memwr_rst cause", cause, 0);
        @(negedge clk);
        resetn = 1'b1;
        return;
      end
      @(negedge clk);
    end
    if (hlt) pulse_reset();
  endtask

  logic [6:0] op_pool [12];
  int r, wf, wm;

  initial begin
    op_pool = '{OP_LOAD, OP_STORE, OP_R, OP_R, OP_IMM, OP_JAL, OP_JALR,
                OP_BRANCH, OP_AUIPC, OP_LUI, OP_FENCE, OP_SYSTEM};
    resetn = 1'b0; mem_ready = 1'b0; md_done = 1'b0;
    op = '0; funct3 = '0; funct7_5 = 1'b0; funct7_0 = 1'b0;
    @(negedge clk);
    #1;
    check("reset state", state_o, ST_FETCH);
    check("reset cause", cause, 0);
    check("reset mem_req", mem_req, 0);
    check("reset halted", halted, 0);
    @(negedge clk);
    resetn = 1'b1;

    instr(OP_R,      3'd0, 0, 0, 0, 0, 0);   // ADD, no waits
    instr(OP_LOAD,   3'd2, 0, 0, 0, 3, 0);   // LW, 3 wait cycles in MEMREAD
    instr(OP_STORE,  3'd2, 0, 0, 1, 2, 0);
    instr(OP_IMM,    3'd0, 0, 0, 2, 0, 0);
    instr(OP_JAL,    3'd0, 0, 0, 0, 0, 0);
    instr(OP_JALR,   3'd0, 0, 0, 1, 0, 0);
    instr(OP_BRANCH, 3'd1, 0, 0, 0, 0, 0);
    instr(OP_AUIPC,  3'd0, 0, 0, 0, 0, 0);
    instr(OP_LUI,    3'd0, 0, 0, 3, 0, 0);
    instr(OP_FENCE,  3'd0, 0, 0, 0, 0, 0);
    instr(OP_R,      3'd0, 1, 0, 15, 0, 0);  // ready on the last allowed cycle
    instr(OP_LOAD,   3'd2, 0, 0, 0, 15, 0);
    instr(OP_R,      3'd0, 0, 0, 100, 0, 0); // fetch timeout
    instr(OP_STORE,  3'd2, 0, 0, 0, 100, 0); // store timeout
    instr(OP_SYSTEM, 3'd0, 0, 0, 0, 0, 0);   // EBREAK/ECALL halt
    instr(OP_R,      3'd0, 0, 0, 0, 0, 0);
    instr(OP_SYSTEM, 3'd1, 0, 0, 0, 0, 0);   // CSR-type: illegal
    instr(OP_SYSTEM, 3'd0, 1, 0, 0, 0, 0);
    instr(OP_R,      3'd0, 0, 1, 0, 0, 5);   // MUL, md_done after 5 cycles
    instr(7'b1111111, 3'd0, 0, 0, 0, 0, 0);  // unlisted opcode
    instr(OP_STORE,  3'd2, 0, 0, 0, 2, 0, 1'b1); // reset mid-MEMWR
    instr(OP_R,      3'd0, 0, 0, 0, 0, 0);

    for (int n = 0; n < 80; n++) begin
      r  = $urandom_range(0, 9);
      wf = (r < 8) ? $urandom_range(0, 3) : ((r == 8) ? 15 : 16);
      r  = $urandom_range(0, 9);
      wm = (r < 8) ? $urandom_range(0, 3) : ((r == 8) ? 15 : 16);
      instr(($urandom_range(0, 15) == 0) ? 7'($urandom) : op_pool[$urandom_range(0, 11)],
            3'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 3) == 0), wf, wm, $urandom_range(0, 6));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mc_control_unit.md
MC_CONTROL_UNIT -- requirements
Module: mc_control_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_W, default 4: memory wait-counter width; bus timeout after 2^TIMEOUT_W-1 wait cycles.
REQ-002 SHALL have parameter SEL_W, default 3: width of alu_src_a, alu_src_b and result_src.
REQ-003 SHALL have ports: clk in 1, rising-edge clock; resetn in 1, asynchronous active-low reset.
REQ-004 SHALL have inputs: op 7, opcode; funct3 3; funct7_5 1, instr[30]; funct7_0 1, instr[25]; mem_ready 1, memory handshake done; md_done 1, mul/div unit done.
REQ-005 SHALL have 1-bit outputs pc_write, ir_write, pc_src, reg_write, imm, mem_write, mem_req, branch, md_start, ebreak, halted.
REQ-006 SHALL have outputs: adr_src 2; alu_op 2; alu_src_a, alu_src_b, result_src SEL_W each; cause 2 (0 none, 1 illegal, 2 bus timeout, 3 ebreak); state_o 5, current state.

Function
REQ-007 SHALL implement states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, JAL, JALR, BRANCH, AUIPC, LUI, MULDIV, HALT.
REQ-008 FETCH: mem_req=1, adr_src=0, alu_src_b=1; stay while mem_ready=0; when mem_ready=1, ir_write=1, pc_write=1 that cycle, go to DECODE.
REQ-009 DECODE: alu_src_a=2, alu_src_b=2; dispatch on op: 0000011/0100011->MEMADR, 0110011->EXECR, 0010011->EXECI, 1101111->JAL, 1100111->JALR, 1100011->BRANCH, 0010111->AUIPC, 0110111->LUI, 0001111 (FENCE)->FETCH.
REQ-010 DECODE with op=1110011, funct3=0, funct7_0=0 and funct7_5=0 (ECALL/EBREAK) SHALL go to HALT with cause=3; any other unlisted op SHALL go to HALT with cause=1.
REQ-011 MEMADR: alu_src_a=1, alu_src_b=2; ->MEMREAD if op=0000011, else MEMWR.
REQ-012 MEMREAD: mem_req=1, adr_src=1; ->MEMWB on mem_ready. MEMWR: mem_req=1, mem_write=1, adr_src=1; ->FETCH on mem_ready.
REQ-013 MEMWB: reg_write=1, result_src=1; ->FETCH. ALUWB: reg_write=1; ->FETCH.
REQ-014 EXECR: alu_src_a=1, alu_op=2; ->ALUWB. EXECI: alu_src_a=1, alu_src_b=2, alu_op=2, imm=1; ->ALUWB.
REQ-015 JAL/JALR: alu_src_a=2, alu_src_b=1, pc_write=1, pc_src=1 (JALR also imm=1); ->ALUWB.
REQ-016 BRANCH: alu_src_a=1, alu_op=1, branch=1, pc_src=1; ->FETCH. AUIPC: alu_src_a=2, alu_src_b=2; LUI: alu_src_a=3, alu_src_b=2; both ->ALUWB.
REQ-017 Outputs not listed for a state SHALL be 0; all outputs combinational from state and inputs.
REQ-018 Wait counter SHALL clear on entering FETCH/MEMREAD/MEMWR, increment each cycle mem_ready=0 in those states; at all-ones with mem_ready=0 SHALL go to HALT, cause=2, without asserting ir_write/pc_write/reg_write.
REQ-019 mem_ready=1 on the cycle the counter reaches all-ones SHALL complete normally (ready wins over timeout).
REQ-020 HALT: halted=1, ebreak=1 iff cause=3, no other strobes; sticky until reset; cause register held.
REQ-021 cause SHALL be a register, written only on HALT entry, 0 otherwise.

Reset
REQ-022 resetn=0 SHALL asynchronously force state=FETCH, wait counter=0, cause=0; first fetch on first rising edge after deassertion.
REQ-023 Reset mid-transaction SHALL drop mem_req/mem_write immediately; no completion of the interrupted access.

Configuration
REQ-024 With MC_CTRL_MULDIV_EN defined, DECODE op=0110011 and funct7_0=1 SHALL go to MULDIV: alu_src_a=1, md_start=1 on entry cycle only, result_src=2, wait for md_done, then ALUWB with result_src=2.
REQ-025 Without MC_CTRL_MULDIV_EN, op=0110011 with funct7_0=1 SHALL go to HALT, cause=1; md_start tied 0; MULDIV state absent.

Structure
REQ-026 State encodings, opcode constants and cause codes SHALL live in shared package mc_ctrl_pkg.
REQ-027 Wait counter with timeout flag SHALL be sub-module mc_wait_timer (param TIMEOUT_W).

Verification
REQ-028 ADD (op=0110011): mem_ready=1 immediately -> FETCH,DECODE,EXECR,ALUWB; reg_write=1 only in cycle 4.
REQ-029 LW with mem_ready low 3 cycles in MEMREAD -> MEMREAD held 4 cycles, then MEMWB reg_write=1, result_src=1.
REQ-030 FETCH with mem_ready held 0, TIMEOUT_W=4 -> HALT after 15 wait cycles, cause=2, halted=1, ir_write never 1.
REQ-031 op=1110011 funct3=0 funct7=0 -> HALT, ebreak=1, cause=3; stays halted until resetn pulse, then FETCH.
REQ-032 MUL (funct7_0=1), macro defined, md_done after 5 cycles -> md_start one cycle, MULDIV 6 cycles, ALUWB; macro undefined -> HALT cause=1.
REQ-033 resetn=0 asserted mid-MEMWR -> mem_write drops same cycle, state_o=FETCH, cause=0.
